// File: rtl/wb_write_arbiter_if.sv
// Write-port bundle between the ALU/MDU producers, the arbiter and the register file.
// Signal names carry the arbiter-side direction suffixes used by the register-file port.
interface wb_write_arbiter_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              alu_valid_i;
  logic [4:0]        alu_rd_i;
  logic [31:0]       alu_data_i;
  logic              mdu_valid_i;
  logic              mdu_ready_o;
  logic [4:0]        mdu_rd_i;
  logic [31:0]       mdu_data_i;
  logic [4:0]        RDaddr_o;
  logic [31:0]       RDdata_o;
  logic              RegWrite_o;
  logic [31:0]       pending_mask_o;
  logic [CNT_W-1:0]  fifo_count_o;

  // Producer / register-file side
  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output mdu_valid_i, mdu_rd_i, mdu_data_i,
    input  mdu_ready_o,
    input  RDaddr_o, RDdata_o, RegWrite_o,
    input  pending_mask_o, fifo_count_o
  );

  // Arbiter side
  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  mdu_valid_i, mdu_rd_i, mdu_data_i,
    output mdu_ready_o,
    output RDaddr_o, RDdata_o, RegWrite_o,
    output pending_mask_o, fifo_count_o
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: ALU writes win every cycle, multi-cycle unit
// results are buffered in a small FIFO and drained when the ALU port is idle.
module wb_write_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  wb_write_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [4:0]            fifo_rd   [FIFO_DEPTH];
  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_valid;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic        not_full;
  logic        push;
  logic        pop;
  logic        alu_issue;
  logic [31:0] pending_mask;

  // Ready depends only on the registered count, so no input reaches it combinationally.
  assign not_full = (count != CNT_W'(FIFO_DEPTH));

  // x0 MDU results complete the handshake but are dropped; an x0 ALU request still owns the port.
  always_comb begin
    push      = bus.mdu_valid_i && not_full && (bus.mdu_rd_i != 5'd0);
    pop       = !bus.alu_valid_i && (count != CNT_W'(0));
    alu_issue = bus.alu_valid_i && (bus.alu_rd_i != 5'd0);
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (fifo_valid[i]) pending_mask[fifo_rd[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  // Payload storage needs no reset; occupancy is tracked by fifo_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.mdu_rd_i;
      fifo_data[wr_ptr] <= bus.mdu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_valid <= '0;
    end else begin
      if (push) begin
        wr_ptr             <= wr_ptr + PTR_W'(1);
        fifo_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr             <= rd_ptr + PTR_W'(1);
        fifo_valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Write-port output registers; address/data hold when nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.RegWrite_o <= 1'b0;
      bus.RDaddr_o   <= '0;
      bus.RDdata_o   <= '0;
    end else if (alu_issue) begin
      bus.RegWrite_o <= 1'b1;
      bus.RDaddr_o   <= bus.alu_rd_i;
      bus.RDdata_o   <= bus.alu_data_i;
    end else if (pop) begin
      bus.RegWrite_o <= 1'b1;
      bus.RDaddr_o   <= fifo_rd[rd_ptr];
      bus.RDdata_o   <= fifo_data[rd_ptr];
    end else begin
      bus.RegWrite_o <= 1'b0;
    end
  end

  assign bus.mdu_ready_o    = not_full;
  assign bus.pending_mask_o = pending_mask;
  assign bus.fifo_count_o   = count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed, table-driven bench for wb_write_arbiter plus hand-written wrap and reset sequences.
module tb_wb_write_arbiter;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;

  wb_write_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

  wb_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_rd;
    logic [31:0] alu_d;
    logic        mdu_v;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_d;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_cnt;
    logic [31:0] e_mask;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];
  int n_cmp;
  int n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic mv, input logic [4:0] mr, input logic [31:0] md,
                     input logic we, input logic [4:0] ea, input logic [31:0] ed,
                     input logic [31:0] ec, input logic [31:0] em, input logic er);
    vec_t v;
    v.alu_v = av; v.alu_rd = ar; v.alu_d = ad;
    v.mdu_v = mv; v.mdu_rd = mr; v.mdu_d = md;
    v.e_we = we; v.e_addr = ea; v.e_data = ed;
    v.e_cnt = ec; v.e_mask = em; v.e_rdy = er;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    bus.alu_valid_i = av; bus.alu_rd_i = ar; bus.alu_data_i = ad;
    bus.mdu_valid_i = mv; bus.mdu_rd_i = mr; bus.mdu_data_i = md;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2;
    chk("rst_we",    32'(bus.RegWrite_o),   32'd0);
    chk("rst_addr",  32'(bus.RDaddr_o),     32'd0);
    chk("rst_data",  bus.RDdata_o,          32'd0);
    chk("rst_cnt",   32'(bus.fifo_count_o), 32'd0);
    chk("rst_mask",  bus.pending_mask_o,    32'd0);
    chk("rst_ready", 32'(bus.mdu_ready_o),  32'd1);
    #11 rst_n = 1'b1;

    // ALU-only write, then idle hold
    add(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0,        1, 5'd5, 32'h1234,     0, 32'h0, 1);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        0, 5'd5, 32'h1234,     0, 32'h0, 1);
    // MDU while idle: two-cycle latency
    add(0, 5'd0, 32'h0,    1, 5'd7, 32'hDEADBEEF, 0, 5'd5, 32'h1234,     1, 32'h80, 1);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        1, 5'd7, 32'hDEADBEEF, 0, 32'h0, 1);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        0, 5'd7, 32'hDEADBEEF, 0, 32'h0, 1);
    // Fill FIFO under ALU starvation
    add(1, 5'd10, 32'hA0,  1, 5'd1, 32'h11,       1, 5'd10, 32'hA0,      1, 32'h02, 1);
    add(1, 5'd11, 32'hB0,  1, 5'd2, 32'h22,       1, 5'd11, 32'hB0,      2, 32'h06, 1);
    add(1, 5'd12, 32'hC0,  1, 5'd3, 32'h33,       1, 5'd12, 32'hC0,      3, 32'h0E, 1);
    add(1, 5'd13, 32'hD0,  1, 5'd4, 32'h44,       1, 5'd13, 32'hD0,      4, 32'h1E, 0);
    add(1, 5'd14, 32'hE0,  0, 5'd0, 32'h0,        1, 5'd14, 32'hE0,      4, 32'h1E, 0);
    // Drain in order once ALU drops
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        1, 5'd1, 32'h11,       3, 32'h1C, 1);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        1, 5'd2, 32'h22,       2, 32'h18, 1);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        1, 5'd3, 32'h33,       1, 32'h10, 1);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        1, 5'd4, 32'h44,       0, 32'h0, 1);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        0, 5'd4, 32'h44,       0, 32'h0, 1);
    // x0 filtering
    add(0, 5'd0, 32'h0,    1, 5'd9, 32'h99,       0, 5'd4, 32'h44,       1, 32'h200, 1);
    add(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'h0,        0, 5'd4, 32'h44,       1, 32'h200, 1);
    add(0, 5'd0, 32'h0,    0, 5'd0, 32'h0,        1, 5'd9, 32'h99,       0, 32'h0, 1);
    add(0, 5'd0, 32'h0,    1, 5'd0, 32'h77,       0, 5'd9, 32'h99,       0, 32'h0, 1);

    foreach (vecs[k]) begin
      drive(vecs[k].alu_v, vecs[k].alu_rd, vecs[k].alu_d,
            vecs[k].mdu_v, vecs[k].mdu_rd, vecs[k].mdu_d);
      tick();
      chk($sformatf("v%0d_we", k),    32'(bus.RegWrite_o),   32'(vecs[k].e_we));
      chk($sformatf("v%0d_addr", k),  32'(bus.RDaddr_o),     32'(vecs[k].e_addr));
      chk($sformatf("v%0d_data", k),  bus.RDdata_o,          vecs[k].e_data);
      chk($sformatf("v%0d_cnt", k),   32'(bus.fifo_count_o), vecs[k].e_cnt);
      chk($sformatf("v%0d_mask", k),  bus.pending_mask_o,    vecs[k].e_mask);
      chk($sformatf("v%0d_ready", k), 32'(bus.mdu_ready_o),  32'(vecs[k].e_rdy));
    end

    // Wrap-around: ten back-to-back MDU entries, one push and one pop per cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i + 1), 32'h1000 + 32'(i));
      tick();
      chk($sformatf("wrap%0d_cnt", i),  32'(bus.fifo_count_o), 32'd1);
      chk($sformatf("wrap%0d_mask", i), bus.pending_mask_o,    32'd1 << (i + 1));
      if (i == 0) begin
        chk("wrap0_we", 32'(bus.RegWrite_o), 32'd0);
      end else begin
        chk($sformatf("wrap%0d_we", i),   32'(bus.RegWrite_o), 32'd1);
        chk($sformatf("wrap%0d_addr", i), 32'(bus.RDaddr_o),   32'(i));
        chk($sformatf("wrap%0d_data", i), bus.RDdata_o,        32'h1000 + 32'(i - 1));
      end
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("wrap_last_we",   32'(bus.RegWrite_o),   32'd1);
    chk("wrap_last_addr", 32'(bus.RDaddr_o),     32'd10);
    chk("wrap_last_data", bus.RDdata_o,          32'h1009);
    chk("wrap_last_cnt",  32'(bus.fifo_count_o), 32'd0);

    // Reset mid-operation with three buffered entries and an active write
    drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h210); tick();
    drive(1'b1, 5'd22, 32'h220, 1'b1, 5'd23, 32'h230); tick();
    drive(1'b1, 5'd24, 32'h240, 1'b1, 5'd25, 32'h250); tick();
    chk("pre_rst_cnt",  32'(bus.fifo_count_o), 32'd3);
    chk("pre_rst_we",   32'(bus.RegWrite_o),   32'd1);
    chk("pre_rst_mask", bus.pending_mask_o,    (32'd1 << 21) | (32'd1 << 23) | (32'd1 << 25));
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    32'(bus.RegWrite_o),   32'd0);
    chk("mid_rst_addr",  32'(bus.RDaddr_o),     32'd0);
    chk("mid_rst_data",  bus.RDdata_o,          32'd0);
    chk("mid_rst_cnt",   32'(bus.fifo_count_o), 32'd0);
    chk("mid_rst_mask",  bus.pending_mask_o,    32'd0);
    chk("mid_rst_ready", 32'(bus.mdu_ready_o),  32'd1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_rst%0d_we", i),  32'(bus.RegWrite_o),   32'd0);
      chk($sformatf("post_rst%0d_cnt", i), 32'(bus.fifo_count_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
